// File: rtl/nr_mem_arbiter_pkg.sv
// nr_mem_arbiter_pkg: shared types and defaults for the two-port memory arbiter.
package nr_mem_arbiter_pkg;
   localparam int DW_DEF = 8;
   localparam int AW_DEF = 4;
   typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B, ACK} state_t;
   typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/nr_rr_arb2.sv
// nr_rr_arb2: two-input round-robin picker; req[0] is port A, req[1] is port B.
module nr_rr_arb2 import nr_mem_arbiter_pkg::*; (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant
);
   // On a tie the port not served last wins; otherwise whoever asks.
   assign grant = &req ? (last == PORT_A) : req[1];
endmodule

// File: rtl/nr_mem_arbiter.sv
// nr_mem_arbiter: arbitrates an instruction-fetch read port and a data read/write port
// onto a single external nR_Memory, one transaction per two cycles.
module nr_mem_arbiter import nr_mem_arbiter_pkg::*; #(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          req_a,
   input  logic [AW-1:0] adr_a,
   output logic          ack_a,
   input  logic          req_b,
   input  logic          we_b,
   input  logic [AW-1:0] adr_b,
   input  logic [DW-1:0] wdata_b,
   output logic          ack_b,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_adrIn,
   output logic [AW-1:0] mem_adrOut,
   output logic [DW-1:0] mem_in,
   output logic          mem_canWrt,
   output logic          mem_canRd,
   input  logic [DW-1:0] mem_out
);
   state_t     state;
   port_t      last;
   logic [1:0] arb_req;
   logic       grant;
   logic       pick_b;
   logic       pick_wr;
   // In ACK the port just served sits out one cycle so the other can follow immediately.
   assign arb_req = state == IDLE ? {req_b, req_a}
                  : state == ACK  ? {req_b & (last != PORT_B), req_a & (last != PORT_A)}
                  : 2'b00;
   assign pick_b  = grant == PORT_B;
   assign pick_wr = pick_b & we_b;
   nr_rr_arb2 u_arb (.req(arb_req), .last(last), .grant(grant));
   always_ff @(posedge clk) begin
      if (clr) begin
         state      <= IDLE;
         last       <= PORT_B;
         rdata      <= '0;
         ack_a      <= 1'b0;
         ack_b      <= 1'b0;
         mem_canRd  <= 1'b0;
         mem_canWrt <= 1'b0;
         mem_adrOut <= '0;
         mem_adrIn  <= '0;
         mem_in     <= '0;
      end else begin
         ack_a      <= 1'b0;
         ack_b      <= 1'b0;
         mem_canRd  <= 1'b0;
         mem_canWrt <= 1'b0;
         mem_adrOut <= '0;
         mem_adrIn  <= '0;
         mem_in     <= '0;
         case (state)
            IDLE, ACK: begin
               state <= IDLE;
               if (|arb_req) begin
                  // Strobes are registered here so they are live for the whole ISSUE cycle.
                  state      <= pick_b ? ISSUE_B : ISSUE_A;
                  last       <= port_t'(grant);
                  mem_canRd  <= !pick_wr;
                  mem_adrOut <= pick_wr ? '0 : pick_b ? adr_b : adr_a;
                  mem_canWrt <= pick_wr;
                  mem_adrIn  <= pick_wr ? adr_b : '0;
                  mem_in     <= pick_wr ? wdata_b : '0;
               end
            end
            default: begin
               state <= ACK;
               if (mem_canRd) rdata <= mem_out;
               ack_a <= state == ISSUE_A;
               ack_b <= state == ISSUE_B;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_nr_mem_arbiter.sv
// tb_nr_mem_arbiter: scoreboard bench for nr_mem_arbiter with a behavioural nR_Memory.
module tb_nr_mem_arbiter;
   localparam int DW = 8;
   localparam int AW = 4;
   logic          clk = 1'b0;
   logic          clr, req_a, req_b, we_b;
   logic [AW-1:0] adr_a, adr_b, mem_adrIn, mem_adrOut;
   logic [DW-1:0] wdata_b, rdata, mem_in, mem_out;
   logic          ack_a, ack_b, mem_canWrt, mem_canRd;
   int            checks = 0;
   int            errors = 0;
   bit            sb_en = 1'b1;
   typedef struct packed {logic port; logic chk; logic [DW-1:0] data;} exp_t;
   exp_t          sb_q[$];
   exp_t          mon_e;
   logic [DW-1:0] mem [16];

   always #5 clk = ~clk;

   nr_mem_arbiter #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .clr(clr),
      .req_a(req_a), .adr_a(adr_a), .ack_a(ack_a),
      .req_b(req_b), .we_b(we_b), .adr_b(adr_b), .wdata_b(wdata_b), .ack_b(ack_b),
      .rdata(rdata), .mem_adrIn(mem_adrIn), .mem_adrOut(mem_adrOut), .mem_in(mem_in),
      .mem_canWrt(mem_canWrt), .mem_canRd(mem_canRd), .mem_out(mem_out)
   );

   initial for (int i = 0; i < 16; i++) mem[i] <= (i == 3) ? 8'h5A : 8'(i * 17);
   always @(negedge clk) if (mem_canRd) mem_out <= mem[mem_adrOut];
   always @(posedge clk) if (mem_canWrt) mem[mem_adrIn] <= mem_in;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] outs();
      return 32'({ack_a, ack_b, rdata, mem_adrIn, mem_adrOut, mem_in, mem_canWrt, mem_canRd});
   endfunction

   // Monitor: every ack pops one expected transaction.
   always @(negedge clk) begin
      if (sb_en && (ack_a || ack_b)) begin
         if (sb_q.size() == 0) begin
            check("unexpected_ack", {ack_a, ack_b}, 2'b00);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_port", {ack_a, ack_b}, mon_e.port ? 2'b01 : 2'b10);
            if (mon_e.chk) check("sb_rdata", rdata, mon_e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input logic port, input logic we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp_d);
      int cyc = 0;
      int wr = 0;
      int rd = 0;
      bit got = 0;
      if (port) begin
         req_b = 1; we_b = we; adr_b = adr; wdata_b = wd;
      end else begin
         req_a = 1; adr_a = adr;
      end
      sb_q.push_back('{port: port, chk: !we, data: exp_d});
      while (!got && cyc < 10) begin
         tick();
         cyc++;
         wr += int'(mem_canWrt);
         rd += int'(mem_canRd);
         if (cyc == 1) begin
            if (we) check("issue_wr", {mem_canWrt, mem_canRd, mem_adrIn, mem_in}, {2'b10, adr, wd});
            else    check("issue_rd", {mem_canRd, mem_canWrt, mem_adrOut}, {2'b10, adr});
         end
         got = port ? ack_b : ack_a;
      end
      check("latency", cyc, 2);
      check("wr_pulses", wr, 32'(we));
      check("rd_pulses", rd, 32'(!we));
      req_a = 0; req_b = 0; we_b = 0;
      tick();
      check("idle_after", {mem_canRd, mem_canWrt, ack_a, ack_b}, 0);
   endtask

   initial begin
      int n, last_n, nacks, wa, wb;
      clr = 1; req_a = 1; req_b = 0; we_b = 0; adr_a = 3; adr_b = 0; wdata_b = 0;
      repeat (3) tick();
      check("reset_outs", outs(), 0);
      tick();
      check("reset_outs_hold", outs(), 0);
      clr = 0; req_a = 0;
      tick();
      check("idle_outs", outs(), 0);
      txn(0, 0, 4'd3, 8'h00, 8'h5A);
      txn(1, 1, 4'd9, 8'hC3, 8'h00);
      txn(1, 0, 4'd9, 8'h00, 8'hC3);
      txn(0, 0, 4'd9, 8'h00, 8'hC3);
      txn(1, 0, 4'd2, 8'h00, 8'h22);
      // Both ports held: eight alternating reads starting with A.
      for (int i = 0; i < 8; i++) sb_q.push_back('{port: i[0], chk: 1'b1, data: i[0] ? 8'hC3 : 8'h5A});
      req_a = 1; adr_a = 3; req_b = 1; we_b = 0; adr_b = 9;
      n = 0; last_n = 0; nacks = 0;
      while (nacks < 8 && n < 40) begin
         tick();
         n++;
         if (ack_a || ack_b) begin
            check("alt_port", ack_b, 32'(nacks % 2));
            check(nacks == 0 ? "alt_first" : "alt_gap", n - last_n, 2);
            last_n = n;
            nacks++;
            if (ack_a && nacks == 7) req_a = 0;
            if (ack_b && nacks == 8) req_b = 0;
         end
      end
      check("alt_count", nacks, 8);
      req_a = 0; req_b = 0;
      tick();
      check("alt_idle", {mem_canRd, mem_canWrt, ack_a, ack_b}, 0);
      // clr during an ISSUE_B write.
      req_b = 1; we_b = 1; adr_b = 5; wdata_b = 8'h77;
      tick();
      check("clr_issue", {mem_canWrt, mem_adrIn}, {1'b1, 4'd5});
      clr = 1; req_b = 0; we_b = 0;
      tick();
      check("clr_outs", outs(), 0);
      clr = 0;
      repeat (3) begin
         tick();
         check("clr_no_ack", {ack_a, ack_b}, 0);
      end
      txn(0, 0, 4'd3, 8'h00, 8'h5A);
      // req_a dropped during ISSUE_A.
      req_a = 1; adr_a = 4'd6;
      sb_q.push_back('{port: 1'b0, chk: 1'b1, data: 8'h66});
      tick();
      req_a = 0;
      tick();
      check("drop_ack", {ack_a, ack_b}, 2'b10);
      tick();
      check("drop_idle", {ack_a, ack_b, mem_canRd, mem_canWrt}, 0);
      tick();
      check("drop_no_ack", {ack_a, ack_b}, 0);
      check("sb_empty", sb_q.size(), 0);
      // Random traffic with protocol properties.
      sb_en = 0; wa = 0; wb = 0;
      repeat (1000) begin
         tick();
         check("strobe_excl", mem_canRd & mem_canWrt, 0);
         check("ack_onehot", ack_a & ack_b, 0);
         check("addr_gate", {mem_canRd ? 4'h0 : mem_adrOut, mem_canWrt ? 4'h0 : mem_adrIn,
                             mem_canWrt ? 8'h00 : mem_in}, 0);
         wa = ack_a ? 0 : wa + int'(req_a);
         wb = ack_b ? 0 : wb + int'(req_b);
         check("starve_a", wa > 4, 0);
         check("starve_b", wb > 4, 0);
         if (ack_a || !req_a) begin
            req_a = 1'($urandom_range(0, 1));
            adr_a = 4'($urandom);
         end
         if (ack_b || !req_b) begin
            req_b = 1'($urandom_range(0, 1));
            we_b = 1'($urandom_range(0, 1));
            adr_b = 4'($urandom);
            wdata_b = 8'($urandom);
         end
      end
      req_a = 0; req_b = 0;
      repeat (4) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
